// File: rtl/pong_pkg.sv
// pong_pkg: display timing totals, palette and object rectangle shared by the speedPong renderer.
package pong_pkg;
  localparam logic [9:0] H_TOTAL = 10'd800;
  localparam logic [9:0] V_TOTAL = 10'd525;
  localparam logic [23:0] COL_BALL = 24'hFFFF00;
  localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
  localparam logic [23:0] COL_NET = 24'h808080;
  localparam logic [23:0] COL_BLACK = 24'h000000;
  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] x2;
    logic [9:0] y1;
    logic [9:0] y2;
  } rect_t;
  // Inclusive bounds; an inverted range simply never matches.
  function automatic logic in_rect(rect_t r, logic [9:0] x, logic [9:0] y);
    return x >= r.x1 && x <= r.x2 && y >= r.y1 && y <= r.y2;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: half-rate pixel enable, raster counters and raw sync/active decode.
module vga_timing_gen
  import pong_pkg::*;
#(
  parameter logic [9:0] H_ACTIVE = 10'd640,
  parameter logic [9:0] H_FP = 10'd16,
  parameter logic [9:0] H_SYNC = 10'd96,
  parameter logic [9:0] H_BP = 10'd48,
  parameter logic [9:0] V_ACTIVE = 10'd480,
  parameter logic [9:0] V_FP = 10'd10,
  parameter logic [9:0] V_SYNC = 10'd2,
  parameter logic [9:0] V_BP = 10'd33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en_o,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       active_o
);
  localparam logic [9:0] HS_LO = H_ACTIVE + H_FP;
  localparam logic [9:0] HS_HI = H_ACTIVE + H_FP + H_SYNC - 10'd1;
  localparam logic [9:0] H_LAST = H_ACTIVE + H_FP + H_SYNC + H_BP - 10'd1;
  localparam logic [9:0] VS_LO = V_ACTIVE + V_FP;
  localparam logic [9:0] VS_HI = V_ACTIVE + V_FP + V_SYNC - 10'd1;
  localparam logic [9:0] V_LAST = V_ACTIVE + V_FP + V_SYNC + V_BP - 10'd1;
  logic       pix_en_q;
  logic [9:0] h_q, h_d, v_q, v_d;
  assign h_d = h_q == H_LAST ? 10'd0 : h_q + 10'd1;
  assign v_d = h_q != H_LAST ? v_q : v_q == V_LAST ? 10'd0 : v_q + 10'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pix_en_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      pix_en_q <= ~pix_en_q;
      if (pix_en_q) begin
        h_q <= h_d;
        v_q <= v_d;
      end
    end
  assign pix_en_o = pix_en_q;
  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;
  assign hsync_o = !(h_q >= HS_LO && h_q <= HS_HI);
  assign vsync_o = !(v_q >= VS_LO && v_q <= VS_HI);
  assign active_o = h_q < H_ACTIVE && v_q < V_ACTIVE;
endmodule

// File: rtl/pong_frame_renderer.sv
// pong_frame_renderer: snapshots game object coordinates once per frame and rasterises
// walls, net, paddles and ball into registered VGA RGB/sync/blank.
module pong_frame_renderer
  import pong_pkg::*;
#(
  parameter logic [9:0] H_ACTIVE = 10'd640,
  parameter logic [9:0] H_FP = 10'd16,
  parameter logic [9:0] H_SYNC = 10'd96,
  parameter logic [9:0] H_BP = 10'd48,
  parameter logic [9:0] V_ACTIVE = 10'd480,
  parameter logic [9:0] V_FP = 10'd10,
  parameter logic [9:0] V_SYNC = 10'd2,
  parameter logic [9:0] V_BP = 10'd33,
  parameter logic [9:0] PAD1_X1 = 10'd20,
  parameter logic [9:0] PAD1_X2 = 10'd29,
  parameter logic [9:0] PAD2_X1 = 10'd610,
  parameter logic [9:0] PAD2_X2 = 10'd619,
  parameter logic [9:0] WALL_H = 10'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] paddle1y1,
  input  logic [9:0] paddle1y2,
  input  logic [9:0] paddle2y1,
  input  logic [9:0] paddle2y2,
  input  logic [9:0] ballx1,
  input  logic [9:0] ballx2,
  input  logic [9:0] bally1,
  input  logic [9:0] bally2,
  output logic       vgaClock,
  output logic       hsync,
  output logic       vsync,
  output logic       syncB,
  output logic       blankB,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frameStart
);
  localparam logic [9:0] NET_X1 = H_ACTIVE / 10'd2 - 10'd2;
  localparam logic [9:0] NET_X2 = H_ACTIVE / 10'd2 + 10'd1;
  logic        pix_en, hs_raw, vs_raw, active;
  logic [9:0]  x, y;
  logic        snap, hit_ball, hit_pad, hit_wall, hit_net;
  rect_t       ball_q, pad1_q, pad2_q;
  logic        hsync_q, vsync_q, blank_q, fs_q;
  logic [23:0] rgb_q, rgb_d;
  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk),
    .rst(reset),
    .pix_en_o(pix_en),
    .h_cnt_o(x),
    .v_cnt_o(y),
    .hsync_o(hs_raw),
    .vsync_o(vs_raw),
    .active_o(active)
  );
  // First blanked line: positions latched here stay fixed for the whole next frame.
  assign snap = pix_en && x == 10'd0 && y == V_ACTIVE;
  assign hit_ball = in_rect(ball_q, x, y);
  assign hit_pad = in_rect(pad1_q, x, y) || in_rect(pad2_q, x, y);
  assign hit_wall = y < WALL_H || y >= V_ACTIVE - WALL_H;
  assign hit_net = x >= NET_X1 && x <= NET_X2 && !y[4];
  always_comb
    rgb_d = !active ? COL_BLACK : hit_ball ? COL_BALL : (hit_pad || hit_wall) ? COL_WHITE :
            hit_net ? COL_NET : COL_BLACK;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ball_q <= {10'd305, 10'd335, 10'd225, 10'd255};
      pad1_q <= {PAD1_X1, PAD1_X2, 10'd180, 10'd300};
      pad2_q <= {PAD2_X1, PAD2_X2, 10'd180, 10'd300};
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      rgb_q <= COL_BLACK;
      fs_q <= 1'b0;
    end else begin
      fs_q <= snap;
      if (snap) begin
        ball_q <= {ballx1, ballx2, bally1, bally2};
        pad1_q <= {PAD1_X1, PAD1_X2, paddle1y1, paddle1y2};
        pad2_q <= {PAD2_X1, PAD2_X2, paddle2y1, paddle2y2};
      end
      if (pix_en) begin
        hsync_q <= hs_raw;
        vsync_q <= vs_raw;
        blank_q <= active;
        rgb_q <= rgb_d;
      end
    end
  assign vgaClock = pix_en;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign syncB = 1'b0;
  assign blankB = blank_q;
  assign {red, green, blue} = rgb_q;
  assign frameStart = fs_q;
endmodule

// File: tb/tb_pong_frame_renderer.sv
// tb_pong_frame_renderer: scaled-geometry raster checks with a per-pixel expectation queue.
module tb_pong_frame_renderer;
  localparam int HA = 48, HFP = 4, HSW = 4, HBP = 4, HT = HA + HFP + HSW + HBP;
  localparam int VA = 36, VFP = 2, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int P1L = 3, P1R = 5, P2L = 42, P2R = 44, WH = 2;
  typedef struct packed { int bx1, bx2, by1, by2, p1a, p1b, p2a, p2b; } shd_t;
  typedef struct packed { int k; logic [27:0] e; } exp_t;
  localparam shd_t SHD_RST = '{305, 335, 225, 255, 180, 300, 180, 300};

  logic clk = 1'b0, reset = 1'b0;
  logic [9:0] p1a, p1b, p2a, p2b, bx1, bx2, by1, by2;
  logic vgaClock, hsync, vsync, syncB, blankB, frameStart;
  logic [7:0] red, green, blue;
  int total = 0, bad = 0, edges = 0;
  exp_t sbq[$];

  pong_frame_renderer #(
    .H_ACTIVE(10'd48), .H_FP(10'd4), .H_SYNC(10'd4), .H_BP(10'd4),
    .V_ACTIVE(10'd36), .V_FP(10'd2), .V_SYNC(10'd2), .V_BP(10'd2),
    .PAD1_X1(10'd3), .PAD1_X2(10'd5), .PAD2_X1(10'd42), .PAD2_X2(10'd44), .WALL_H(10'd2)
  ) dut (
    .clk(clk), .reset(reset),
    .paddle1y1(p1a), .paddle1y2(p1b), .paddle2y1(p2a), .paddle2y2(p2b),
    .ballx1(bx1), .ballx2(bx2), .bally1(by1), .bally2(by2),
    .vgaClock(vgaClock), .hsync(hsync), .vsync(vsync), .syncB(syncB), .blankB(blankB),
    .red(red), .green(green), .blue(blue), .frameStart(frameStart)
  );

  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) edges <= 0;
    else edges <= edges + 1;

  function automatic logic [27:0] expect_px(int k, shd_t s);
    int h, v;
    logic fs, hs, vs, act;
    logic [23:0] c;
    h = k % HT;
    v = (k / HT) % VT;
    fs = (h == 0 && v == VA);
    hs = !(h >= HA + HFP && h < HA + HFP + HSW);
    vs = !(v >= VA + VFP && v < VA + VFP + VSW);
    act = h < HA && v < VA;
    if (!act) c = 24'h000000;
    else if (h >= s.bx1 && h <= s.bx2 && v >= s.by1 && v <= s.by2) c = 24'hFFFF00;
    else if ((h >= P1L && h <= P1R && v >= s.p1a && v <= s.p1b) ||
             (h >= P2L && h <= P2R && v >= s.p2a && v <= s.p2b) || v < WH || v >= VA - WH)
      c = 24'hFFFFFF;
    else if (h >= HA / 2 - 2 && h <= HA / 2 + 1 && (v / 16) % 2 == 0) c = 24'h808080;
    else c = 24'h000000;
    return {fs, hs, vs, act, c};
  endfunction

  function automatic shd_t cur_shd();
    shd_t s;
    s.bx1 = int'(bx1); s.bx2 = int'(bx2); s.by1 = int'(by1); s.by2 = int'(by2);
    s.p1a = int'(p1a); s.p1b = int'(p1b); s.p2a = int'(p2a); s.p2b = int'(p2b);
    return s;
  endfunction

  task automatic push_frame(input int f, input shd_t s);
    exp_t ent;
    for (int k = f * FT; k < (f + 1) * FT; k++) begin
      ent.k = k;
      ent.e = expect_px(k, s);
      sbq.push_back(ent);
    end
  endtask

  // Output for pixel k is settled at the negedge following the (2k+2)-th clock after release.
  task automatic wait_pixel(input int k);
    int n = 0;
    while (edges != 2 * k + 2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (edges != 2 * k + 2) begin
      total++; bad++;
      $display("FAIL wait_pixel k=%0d edges=%0d required=%0d", k, edges, 2 * k + 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "pixel wait expired");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total += 7;
    if (vgaClock !== 1'b0) begin bad++; $display("FAIL reset_vgaclock got=%b exp=0", vgaClock); end
    if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
    if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
    if (blankB !== 1'b0) begin bad++; $display("FAIL reset_blank got=%b exp=0", blankB); end
    if ({red, green, blue} !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=000000", {red, green, blue}); end
    if (frameStart !== 1'b0) begin bad++; $display("FAIL reset_framestart got=%b exp=0", frameStart); end
    if (syncB !== 1'b0) begin bad++; $display("FAIL syncb got=%b exp=0", syncB); end
    reset = 1'b0;
  endtask

  task automatic test_hsync();
    int hf1 = -1, hr1 = -1, hf2 = -1, br = -1, bf = -1;
    logic hp = 1'b1, bp = 1'b0;
    do_reset();
    for (int n = 1; n <= 240; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        total++;
        if (vgaClock !== n[0]) begin bad++; $display("FAIL vgaclock n=%0d got=%b exp=%b", n, vgaClock, n[0]); end
      end
      if (hp && !hsync) begin if (hf1 < 0) hf1 = n; else if (hf2 < 0) hf2 = n; end
      if (!hp && hsync && hr1 < 0) hr1 = n;
      if (!bp && blankB && br < 0) br = n;
      if (bp && !blankB && bf < 0) bf = n;
      hp = hsync;
      bp = blankB;
    end
    total += 5;
    if (hf1 !== 2 * (HA + HFP) + 2) begin bad++; $display("FAIL hsync_fall got=%0d exp=%0d", hf1, 2 * (HA + HFP) + 2); end
    if (hr1 !== 2 * (HA + HFP + HSW) + 2) begin bad++; $display("FAIL hsync_rise got=%0d exp=%0d", hr1, 2 * (HA + HFP + HSW) + 2); end
    if (hf2 !== 2 * (HA + HFP + HT) + 2) begin bad++; $display("FAIL line_period got=%0d exp=%0d", hf2, 2 * (HA + HFP + HT) + 2); end
    if (br !== 2) begin bad++; $display("FAIL blank_rise got=%0d exp=2", br); end
    if (bf !== 2 * HA + 2) begin bad++; $display("FAIL blank_fall got=%0d exp=%0d", bf, 2 * HA + 2); end
  endtask

  task automatic test_vsync();
    int vf1 = -1, vr1 = -1, vf2 = -1, fs1 = -1, fs2 = -1, fsn = 0;
    logic vp = 1'b1;
    do_reset();
    for (int n = 1; n <= 9700; n++) begin
      @(negedge clk);
      if (vp && !vsync) begin if (vf1 < 0) vf1 = n; else if (vf2 < 0) vf2 = n; end
      if (!vp && vsync && vr1 < 0) vr1 = n;
      vp = vsync;
      if (frameStart) begin
        fsn++;
        if (fs1 < 0) fs1 = n; else if (fs2 < 0) fs2 = n;
      end
    end
    total += 6;
    if (vf1 !== 2 * (VA + VFP) * HT + 2) begin bad++; $display("FAIL vsync_fall got=%0d exp=%0d", vf1, 2 * (VA + VFP) * HT + 2); end
    if (vr1 !== 2 * (VA + VFP + VSW) * HT + 2) begin bad++; $display("FAIL vsync_rise got=%0d exp=%0d", vr1, 2 * (VA + VFP + VSW) * HT + 2); end
    if (vf2 !== 2 * ((VA + VFP) * HT + FT) + 2) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", vf2, 2 * ((VA + VFP) * HT + FT) + 2); end
    if (fs1 !== 2 * VA * HT + 2) begin bad++; $display("FAIL framestart_first got=%0d exp=%0d", fs1, 2 * VA * HT + 2); end
    if (fs2 !== 2 * (VA * HT + FT) + 2) begin bad++; $display("FAIL framestart_second got=%0d exp=%0d", fs2, 2 * (VA * HT + FT) + 2); end
    if (fsn !== 2) begin bad++; $display("FAIL framestart_count got=%0d exp=2", fsn); end
  endtask

  task automatic test_ball();
    exp_t ent;
    logic [27:0] got;
    bx1 = 10'd20; bx2 = 10'd24; by1 = 10'd10; by2 = 10'd13;
    p1a = 10'd0; p1b = 10'd12; p2a = 10'd20; p2b = 10'd30;
    do_reset();
    push_frame(0, SHD_RST);
    push_frame(1, cur_shd());
    while (sbq.size() != 0) begin
      ent = sbq.pop_front();
      wait_pixel(ent.k);
      got = {frameStart, hsync, vsync, blankB, red, green, blue};
      total++;
      if (got !== ent.e) begin
        bad++;
        $display("FAIL ball_pix k=%0d h=%0d v=%0d got=%h exp=%h", ent.k, ent.k % HT, (ent.k / HT) % VT, got, ent.e);
      end
    end
  endtask

  task automatic test_snapshot();
    exp_t ent;
    logic [27:0] got;
    int chg = 2 * FT + 11 * HT;
    push_frame(2, cur_shd());
    while (sbq.size() != 0) begin
      ent = sbq.pop_front();
      wait_pixel(ent.k);
      got = {frameStart, hsync, vsync, blankB, red, green, blue};
      total++;
      if (got !== ent.e) begin
        bad++;
        $display("FAIL snapshot_pix k=%0d h=%0d v=%0d got=%h exp=%h", ent.k, ent.k % HT, (ent.k / HT) % VT, got, ent.e);
      end
      if (ent.k == chg) begin
        bx1 = 10'd2; bx2 = 10'd4; by1 = 10'd8; by2 = 10'd10;
        push_frame(3, cur_shd());
      end
    end
  endtask

  task automatic test_inverted_paddle();
    exp_t ent;
    logic [27:0] got;
    shd_t s_old = cur_shd();
    p1a = 10'd30; p1b = 10'd5;
    push_frame(4, s_old);
    push_frame(5, cur_shd());
    while (sbq.size() != 0) begin
      ent = sbq.pop_front();
      wait_pixel(ent.k);
      got = {frameStart, hsync, vsync, blankB, red, green, blue};
      total++;
      if (got !== ent.e) begin
        bad++;
        $display("FAIL inverted_pix k=%0d h=%0d v=%0d got=%h exp=%h", ent.k, ent.k % HT, (ent.k / HT) % VT, got, ent.e);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t ent;
    logic [27:0] got;
    wait_pixel(6 * FT + 10 * HT + 20);
    #2 reset = 1'b1;
    #1;
    got = {frameStart, hsync, vsync, blankB, red, green, blue};
    total += 2;
    if (got !== {4'b0110, 24'h0}) begin bad++; $display("FAIL async_reset_outputs got=%h exp=%h", got, {4'b0110, 24'h0}); end
    if (vgaClock !== 1'b0) begin bad++; $display("FAIL async_reset_vgaclock got=%b exp=0", vgaClock); end
    repeat (3) @(negedge clk);
    got = {frameStart, hsync, vsync, blankB, red, green, blue};
    total++;
    if (got !== {4'b0110, 24'h0}) begin bad++; $display("FAIL held_reset_outputs got=%h exp=%h", got, {4'b0110, 24'h0}); end
    reset = 1'b0;
    push_frame(0, SHD_RST);
    while (sbq.size() != 0) begin
      ent = sbq.pop_front();
      wait_pixel(ent.k);
      got = {frameStart, hsync, vsync, blankB, red, green, blue};
      total++;
      if (got !== ent.e) begin
        bad++;
        $display("FAIL after_reset_pix k=%0d h=%0d v=%0d got=%h exp=%h", ent.k, ent.k % HT, (ent.k / HT) % VT, got, ent.e);
      end
    end
  endtask

  initial begin
    {p1a, p1b, p2a, p2b, bx1, bx2, by1, by2} = '0;
    test_reset();
    test_hsync();
    test_vsync();
    test_ball();
    test_snapshot();
    test_inverted_paddle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
